// File: rtl/spike_bin_collect.sv
// Collects per-channel spike hits over 8-frame bins and hands completed bins to a packer via a shadow bitmap.
// Optional saturating dropped-bin counter is enabled by defining SPIKE_BIN_DROP_CNT_EN.
module spike_bin_collect #(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spike_valid,
  input  logic [6:0]            spike_ch,
  input  logic                  spike_hit,
  input  logic                  onepacket_finish,
  output logic [63:0]           spike_data_0,
  output logic [63:0]           spike_data_1,
  output logic                  wr_start,
  output logic [2:0]            cntx,
  output logic                  bin_drop,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_t;

  state_t         state_reg, state_next;
  logic [127:0]   acc_reg;
  logic [127:0]   shadow_reg;
  logic [127:0]   hit_vec;
  logic [127:0]   acc_with_hit;
  logic [2:0]     fcnt_reg;
  logic           bin_drop_reg;
  logic           frame_end;
  logic           bin_end;
  logic           load;
  logic           drop;

  // One-hot decode of the current sample's hit, so the closing cycle's hit can join the load.
  genvar gi;
  generate
    for (gi = 0; gi < 128; gi++) begin : g_hit
      assign hit_vec[gi] = spike_valid && spike_hit && (spike_ch == 7'(gi));
    end
  endgenerate

  assign acc_with_hit = acc_reg | hit_vec;
  assign frame_end    = spike_valid && (spike_ch == 7'd127);
  assign bin_end      = frame_end && (fcnt_reg == 3'd7);

  // A finish arriving with the bin end frees the shadow in time for the new bin.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bin_end) begin
          load       = 1'b1;
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (bin_end) begin
          if (onepacket_finish) load = 1'b1;
          else                  drop = 1'b1;
        end else if (onepacket_finish) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      shadow_reg   <= '0;
      fcnt_reg     <= 3'd0;
      bin_drop_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (spike_valid) begin
        acc_reg <= bin_end ? '0 : acc_with_hit;
      end
      if (frame_end) begin
        fcnt_reg <= fcnt_reg + 3'd1;
      end
      if (load) begin
        shadow_reg <= acc_with_hit;
      end
      if (drop) begin
        bin_drop_reg <= 1'b1;
      end
    end
  end

`ifdef SPIKE_BIN_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = '0;
`endif

  assign spike_data_0 = shadow_reg[63:0];
  assign spike_data_1 = shadow_reg[127:64];
  assign wr_start     = (state_reg == ST_PEND);
  assign cntx         = wr_start ? 3'd7 : fcnt_reg;
  assign bin_drop     = bin_drop_reg;

endmodule

// File: tb/tb_spike_bin_collect.sv
// Self-checking bench for spike_bin_collect: vector table, directed corner sequences, and randomized
// traffic checked against a bin-level reference model. Honours SPIKE_BIN_DROP_CNT_EN for drop_cnt.
module tb_spike_bin_collect;
  localparam int DCW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           spike_valid;
  logic [6:0]     spike_ch;
  logic           spike_hit;
  logic           onepacket_finish;
  logic [63:0]    spike_data_0;
  logic [63:0]    spike_data_1;
  logic           wr_start;
  logic [2:0]     cntx;
  logic           bin_drop;
  logic [DCW-1:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  spike_bin_collect #(.DROP_CNT_W(DCW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .spike_valid      (spike_valid),
    .spike_ch         (spike_ch),
    .spike_hit        (spike_hit),
    .onepacket_finish (onepacket_finish),
    .spike_data_0     (spike_data_0),
    .spike_data_1     (spike_data_1),
    .wr_start         (wr_start),
    .cntx             (cntx),
    .bin_drop         (bin_drop),
    .drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: set of hit channels in the open bin, total frames seen, and the packet hand-off.
  bit           m_hits[128];
  bit           m_shadow[128];
  int           m_frames;
  bit           m_pend;
  bit           m_drop;
  int           m_drops;

  function automatic logic [127:0] set_to_vec(input bit s[128]);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 128; i++) v[i] = s[i];
    return v;
  endfunction

  function automatic logic [DCW-1:0] exp_drop_cnt();
`ifdef SPIKE_BIN_DROP_CNT_EN
    int mx;
    mx = (1 << DCW) - 1;
    return DCW'((m_drops > mx) ? mx : m_drops);
`else
    return '0;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    logic [127:0] sh;
    sh = set_to_vec(m_shadow);
    check({tag, ".data0"}, 128'(spike_data_0), 128'(sh[63:0]));
    check({tag, ".data1"}, 128'(spike_data_1), 128'(sh[127:64]));
    check({tag, ".wr_start"}, 128'(wr_start), 128'(m_pend));
    check({tag, ".cntx"}, 128'(cntx), m_pend ? 128'd7 : 128'(m_frames % 8));
    check({tag, ".bin_drop"}, 128'(bin_drop), 128'(m_drop));
    check({tag, ".drop_cnt"}, 128'(drop_cnt), 128'(exp_drop_cnt()));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      m_hits[i]   = 1'b0;
      m_shadow[i] = 1'b0;
    end
    m_frames = 0;
    m_pend   = 1'b0;
    m_drop   = 1'b0;
    m_drops  = 0;
  endtask

  task automatic model_step(input bit v, input int ch, input bit hit, input bit fin);
    bit closing;
    if (v && hit) m_hits[ch] = 1'b1;
    closing = v && (ch == 127) && (m_frames % 8 == 7);
    if (closing) begin
      if (!m_pend || fin) begin
        m_shadow = m_hits;
        m_pend   = 1'b1;
      end else begin
        m_drop = 1'b1;
        m_drops++;
      end
      for (int i = 0; i < 128; i++) m_hits[i] = 1'b0;
    end else if (fin) begin
      m_pend = 1'b0;
    end
    if (v && ch == 127) m_frames++;
  endtask

  task automatic step(input bit v, input int ch, input bit hit, input bit fin, input string tag);
    @(negedge clk);
    spike_valid      = v;
    spike_ch         = 7'(ch);
    spike_hit        = hit;
    onepacket_finish = fin;
    model_step(v, ch, hit, fin);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    spike_valid      = 1'b1;
    spike_ch         = 7'd127;
    spike_hit        = 1'b1;
    onepacket_finish = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_model("reset");
    @(negedge clk);
    rst_n       = 1'b1;
    spike_valid = 1'b0;
    spike_hit   = 1'b0;
  endtask

  task automatic frames127(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 127, 1'b0, 1'b0, tag);
  endtask

  typedef struct {
    logic        v;
    int          ch;
    logic        hit;
    logic        fin;
    logic        wr;
    logic [2:0]  cx;
    logic        bd;
    logic [63:0] d0;
    logic [63:0] d1;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [63:0] top_bit;
    top_bit = 64'h8000_0000_0000_0000;
    // Short frames (ch127 only) keep bins eight cycles long; ch5 hit in frame 1, ch127 hit on the closing cycle.
    tbl[0]  = '{1'b1, 127, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 64'h0,  64'h0};
    tbl[1]  = '{1'b1,   5, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 64'h0,  64'h0};
    tbl[2]  = '{1'b1, 127, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 64'h0,  64'h0};
    tbl[3]  = '{1'b1, 127, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 64'h0,  64'h0};
    tbl[4]  = '{1'b1, 127, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 64'h0,  64'h0};
    tbl[5]  = '{1'b1, 127, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 64'h0,  64'h0};
    tbl[6]  = '{1'b1, 127, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 64'h0,  64'h0};
    tbl[7]  = '{1'b1, 127, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 64'h0,  64'h0};
    tbl[8]  = '{1'b1, 127, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 64'h20, top_bit};
    tbl[9]  = '{1'b0,   0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 64'h20, top_bit};
    tbl[10] = '{1'b1, 127, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 64'h20, top_bit};

    rst_n = 1'b1; spike_valid = 1'b0; spike_ch = '0; spike_hit = 1'b0; onepacket_finish = 1'b0;
    model_reset();
    do_reset();

    for (int r = 0; r < 11; r++) begin
      string t;
      t = $sformatf("tbl%0d", r);
      step(tbl[r].v, tbl[r].ch, tbl[r].hit, tbl[r].fin, t);
      check({t, ".wr"},   128'(wr_start),     128'(tbl[r].wr));
      check({t, ".cntx"}, 128'(cntx),         128'(tbl[r].cx));
      check({t, ".bd"},   128'(bin_drop),     128'(tbl[r].bd));
      check({t, ".d0"},   128'(spike_data_0), 128'(tbl[r].d0));
      check({t, ".d1"},   128'(spike_data_1), 128'(tbl[r].d1));
      $display("vec %0d: v=%0b ch=%0d hit=%0b fin=%0b -> wr=%0b cntx=%0d bd=%0b", r,
               tbl[r].v, tbl[r].ch, tbl[r].hit, tbl[r].fin, wr_start, cntx, bin_drop);
    end

    // Overflow: pending packet, another full bin arrives without a finish.
    do_reset();
    step(1'b1, 10, 1'b1, 1'b0, "ovf");
    frames127(8, "ovf");
    check("ovf.load_d0", 128'(spike_data_0), 128'(64'h400));
    step(1'b1, 20, 1'b1, 1'b0, "ovf");
    frames127(8, "ovf");
    check("ovf.keep_d0", 128'(spike_data_0), 128'(64'h400));
    check("ovf.bin_drop", 128'(bin_drop), 128'd1);
`ifdef SPIKE_BIN_DROP_CNT_EN
    check("ovf.drop_cnt", 128'(drop_cnt), 128'd1);
`else
    check("ovf.drop_cnt", 128'(drop_cnt), 128'd0);
`endif
    step(1'b0, 0, 1'b0, 1'b1, "ovf_fin");
    check("ovf.wr_clear", 128'(wr_start), 128'd0);
    check("ovf.sticky", 128'(bin_drop), 128'd1);
    $display("seq overflow: d0=%0h bin_drop=%0b drop_cnt=%0d wr=%0b", spike_data_0, bin_drop, drop_cnt, wr_start);

    // Bin end coincident with finish: new bitmap loads, wr_start stays high, no drop.
    do_reset();
    step(1'b1, 1, 1'b1, 1'b0, "coin");
    frames127(8, "coin");
    check("coin.first_d0", 128'(spike_data_0), 128'd2);
    step(1'b1, 2, 1'b1, 1'b0, "coin");
    frames127(7, "coin");
    step(1'b1, 127, 1'b0, 1'b1, "coin_end");
    check("coin.d0", 128'(spike_data_0), 128'd4);
    check("coin.wr", 128'(wr_start), 128'd1);
    check("coin.bd", 128'(bin_drop), 128'd0);
    check("coin.cntx", 128'(cntx), 128'd7);
    $display("seq coincident: d0=%0h wr=%0b bin_drop=%0b", spike_data_0, wr_start, bin_drop);

    // Reset during frame 4 with hits pending; the next bin holds only post-reset hits.
    do_reset();
    step(1'b1, 3, 1'b1, 1'b0, "mid");
    frames127(4, "mid");
    step(1'b1, 7, 1'b1, 1'b0, "mid");
    check("mid.cntx_pre", 128'(cntx), 128'd4);
    do_reset();
    check("mid.rst_d0", 128'(spike_data_0), 128'd0);
    check("mid.rst_cntx", 128'(cntx), 128'd0);
    check("mid.rst_wr", 128'(wr_start), 128'd0);
    step(1'b1, 9, 1'b1, 1'b0, "mid");
    frames127(8, "mid");
    check("mid.d0", 128'(spike_data_0), 128'h200);
    check("mid.d1", 128'(spike_data_1), 128'd0);
    check("mid.wr", 128'(wr_start), 128'd1);
    $display("seq mid-reset: d0=%0h d1=%0h wr=%0b", spike_data_0, spike_data_1, wr_start);

    // Saturation: one load then 256 discarded bins.
    do_reset();
    frames127(8, "sat");
    for (int b = 0; b < 256; b++) frames127(8, "sat");
`ifdef SPIKE_BIN_DROP_CNT_EN
    check("sat.drop_cnt", 128'(drop_cnt), 128'hFF);
`else
    check("sat.drop_cnt", 128'(drop_cnt), 128'd0);
`endif
    check("sat.bin_drop", 128'(bin_drop), 128'd1);
    $display("seq saturate: drop_cnt=%0h bin_drop=%0b", drop_cnt, bin_drop);

    // Randomized traffic against the model; mostly ch127 samples so bins close quickly.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit v, hit, fin;
      int ch;
      v   = ($urandom_range(0, 7) != 0);
      ch  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : 127;
      hit = ($urandom_range(0, 2) == 0);
      fin = ($urandom_range(0, 9) == 0);
      step(v, ch, hit, fin, "rand");
    end
    $display("random: 3000 cycles, last d0=%0h d1=%0h wr=%0b drop_cnt=%0d", spike_data_0, spike_data_1, wr_start, drop_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
